// File: rtl/shift_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_pkg
// Description : Shared types for the shift/rotate sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_seq_pkg;

    typedef enum logic [2:0] {
        OP_LSL = 3'd0,
        OP_LSR = 3'd1,
        OP_ASR = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } shift_op_e;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_e;

endpackage
`default_nettype wire

// File: rtl/shift_seq_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_unit_if
// Description : Control/data bundle between a shift client and shift_seq_unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface shift_seq_unit_if #(
    parameter int WIDTH = 64,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             load;
    logic [WIDTH-1:0] data;
    logic             ena;
    logic             big;
    logic [2:0]       op;
    logic             start;
    logic [CW-1:0]    count;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] q;

    modport master (
        output load, data, ena, big, op, start, count,
        input  busy, done, q
    );

    modport slave (
        input  load, data, ena, big, op, start, count,
        output busy, done, q
    );
endinterface
`default_nettype wire

// File: rtl/shift_step_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_step_unit
// Description : Combinational one-step shift/rotate by 1 or STEP bits.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_step_unit
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int STEP  = 8
) (
    input  logic [WIDTH-1:0] q,
    input  logic [2:0]       op,
    input  logic             big,
    output logic [WIDTH-1:0] q_next
);
    logic signed [WIDTH-1:0] w_qs;
    logic        [WIDTH-1:0] w_lsl;
    logic        [WIDTH-1:0] w_lsr;
    logic        [WIDTH-1:0] w_asr;
    logic        [WIDTH-1:0] w_rol;
    logic        [WIDTH-1:0] w_ror;

    assign w_qs = q;

    // Both step sizes are constant shifts, so each leg is pure wiring.
    assign w_lsl = big ? (q << STEP) : (q << 1);
    assign w_lsr = big ? (q >> STEP) : (q >> 1);
    assign w_asr = big ? (w_qs >>> STEP) : (w_qs >>> 1);
    assign w_rol = big ? {q[WIDTH-1-STEP:0], q[WIDTH-1:WIDTH-STEP]}
                       : {q[WIDTH-2:0], q[WIDTH-1]};
    assign w_ror = big ? {q[STEP-1:0], q[WIDTH-1:STEP]}
                       : {q[0], q[WIDTH-1:1]};

    always_comb begin
        q_next = q;
        case (op)
            OP_LSL:  q_next = w_lsl;
            OP_LSR:  q_next = w_lsr;
            OP_ASR:  q_next = w_asr;
            OP_ROL:  q_next = w_rol;
            OP_ROR:  q_next = w_ror;
            default: q_next = q;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/shift_seq_unit.sv
`default_nettype none
// ============================================================================
// Module      : shift_seq_unit
// Description : Parametrised shift/rotate register with single-step control
//               and a multi-cycle "shift by N" sequencer (busy/done).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_seq_unit #(
    parameter int WIDTH = 64,
    parameter int STEP  = 8,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             areset_n,
    shift_seq_unit_if.slave  bus
);
    import shift_seq_pkg::*;

    localparam logic [CW-1:0] c_width = CW'(WIDTH);
    localparam logic [CW-1:0] c_step  = CW'(STEP);
    localparam logic [CW-1:0] c_one   = CW'(1);

    seq_state_e       r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q, w_q_nxt;
    logic [CW-1:0]    r_rem, w_rem_nxt;
    logic [2:0]       r_op, w_op_nxt;
    logic             r_done, w_done_nxt;

    logic [2:0]       w_step_op;
    logic             w_step_big;
    logic [WIDTH-1:0] w_step_q;
    logic [CW-1:0]    w_count_sat;
    logic [CW-1:0]    w_rem_dec;

    // One step unit serves both paths: live controls in IDLE, latched op in RUN.
    assign w_step_op  = (r_state == RUN) ? r_op : bus.op;
    assign w_step_big = (r_state == RUN) ? (r_rem >= c_step) : bus.big;

    shift_step_unit #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .q      (r_q),
        .op     (w_step_op),
        .big    (w_step_big),
        .q_next (w_step_q)
    );

    assign w_count_sat = (bus.count > c_width) ? c_width : bus.count;
    assign w_rem_dec   = r_rem - (w_step_big ? c_step : c_one);

    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_rem_nxt   = r_rem;
        w_op_nxt    = r_op;
        w_done_nxt  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.load) begin
                    w_q_nxt = bus.data;
                end else if (bus.start) begin
                    if (w_count_sat != '0) begin
                        w_op_nxt    = bus.op;
                        w_rem_nxt   = w_count_sat;
                        w_state_nxt = RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end else if (bus.ena) begin
                    w_q_nxt = w_step_q;
                end
            end
            RUN: begin
                // A load aborts the sequence silently: no done pulse.
                if (bus.load) begin
                    w_q_nxt     = bus.data;
                    w_rem_nxt   = '0;
                    w_state_nxt = IDLE;
                end else begin
                    w_q_nxt   = w_step_q;
                    w_rem_nxt = w_rem_dec;
                    if (w_rem_dec == '0) begin
                        w_state_nxt = IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            r_state <= IDLE;
            r_q     <= '0;
            r_rem   <= '0;
            r_op    <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_rem   <= w_rem_nxt;
            r_op    <= w_op_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign bus.q    = r_q;
    assign bus.busy = (r_state == RUN);
    assign bus.done = r_done;
endmodule
`default_nettype wire

// File: doc/shift_seq_unit.md
# shift_seq_unit

Parametrised shift/rotate register for the datapath shift stage. It generalises the fixed 64-bit load/shift register to any width, with a configurable large step and rotate modes. It also adds a multi-cycle "shift by N" sequencer with a busy/done handshake. Single-step shifts under `ena` remain available for simple control paths; the sequencer serves the arithmetic units that need arbitrary shift counts.

## Interface
Parameters:
- `WIDTH`, 64, register width in bits; must be ≥ 2.
- `STEP`, 8, bit distance of a large step; must satisfy 2 ≤ `STEP` < `WIDTH`.
- `CW`, `$clog2(WIDTH+1)`, width of the `count` port (derived; do not override).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `areset_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  load `data` into `q`; highest priority.
- `data`  in  `WIDTH`  parallel load value.
- `ena`  in  1  perform one single-step operation (IDLE only).
- `big`  in  1  with `ena`: step by `STEP` bits instead of 1.
- `op`  in  3  operation select: 0 LSL, 1 LSR, 2 ASR, 3 ROL, 4 ROR, 5–7 reserved.
- `start`  in  1  begin a sequenced shift of `count` bits (IDLE only).
- `count`  in  `CW`  sequenced shift amount, 0..`WIDTH`; larger values saturate to `WIDTH`.
- `busy`  out  1  high while the sequencer is in RUN.
- `done`  out  1  one-cycle completion pulse.
- `q`  out  `WIDTH`  register contents.

## Operation
- Reset, asynchronous: `q`=0, `busy`=0, `done`=0, state IDLE, remaining count 0.
- Operation semantics per step of k bits (k = 1 or `STEP`):
  - LSL: zero fill.
  - LSR: zero fill.
  - ASR: sign fill from `q[WIDTH-1]`.
  - ROL / ROR: wrap-around.
  - Reserved ops: `q` holds.
- Priority in IDLE: `load` > `start` > `ena`.
  - `load`: `q`←`data`.
  - `start` with `count`≠0: latch `op` and `min(count, WIDTH)` as the remaining count; go to RUN.
  - `start` with `count`=0: `q` holds; `done` pulses next cycle; stay in IDLE.
  - `ena` (no `load`/`start`): one step of `op`, size per `big`.
- RUN, each cycle:
  - If remaining ≥ `STEP`: shift by `STEP` and remaining −= `STEP`.
  - Otherwise: shift by 1 and remaining −= 1.
  - When remaining reaches 0: return to IDLE and pulse `done`.
- In RUN, `ena`, `start`, `op` and `count` are ignored; the latched `op` is used throughout.
- `load` in RUN aborts the sequence: `q`←`data`, return to IDLE, remaining←0, no `done` pulse.
- Reserved op in a sequence: `q` holds, but the counter still runs to completion and `done` still pulses.
- Shift of `WIDTH` bits results:
  - LSL / LSR: 0.
  - ASR: all sign bits.
  - ROL / ROR: `q` unchanged.

## Timing
- Single step: `q` updates on the edge where `ena`=1 is sampled; one-cycle latency.
- Sequenced shift of N bits (after saturation) takes floor(N/`STEP`) + (N mod `STEP`) cycles.
- `busy` rises on the edge that samples `start` and falls on the edge of the final shift.
- `done` goes high on that same final edge, coincident with `busy` falling, and stays high exactly one cycle.
- `start` with `count`=0: `done` high for the one cycle after the sampling edge; `busy` stays 0.
- A new `start` is accepted in the same cycle that `done` is high; `busy` then rises again at the next edge.
- Reset mid-run: outputs go to reset values immediately; no `done` pulse.

## Structure
- Package `shift_seq_pkg`:
  - `shift_op_e` enum: LSL, LSR, ASR, ROL, ROR.
  - `seq_state_e` enum: IDLE, RUN.
- Sub-module `shift_step_unit`: combinational, parametrised by `WIDTH` and `STEP`. Inputs are `q`, `op` and a big/single select; output is the next value. Both the `ena` path and the RUN path use it.
- Top level holds `q`, the state register, the remaining counter, the latched op, and the `done` flop.

## Test plan
All scenarios use `WIDTH`=64, `STEP`=8.
- ASR: load 64'h8000_0000_0000_0000, then `ena`, `big`=0 → 64'hC000_0000_0000_0000. Next `ena`, `big`=1 → 64'hFFC0_0000_0000_0000.
- Sequenced LSL: load 64'h1, `start`, `count`=19 → `busy` for 5 cycles (two 8-bit steps, three 1-bit steps), final `q`=64'h8_0000, single `done` pulse.
- Full rotate: load 64'h0123_4567_89AB_CDEF, ROR, `count`=64 → 8 busy cycles, `q` returns to 64'h0123_4567_89AB_CDEF, `done` pulse.
- Saturation and zero count:
  - `count`=100 with LSL on 64'hFFFF → 8 cycles, `q`=0.
  - `count`=0 → `done` next cycle, `busy` never asserts, `q` unchanged.
- Abort: `load` of 64'hA5 in the 2nd RUN cycle of a `count`=40 LSR → `q`=64'hA5 next cycle, `busy`=0, no `done`. `ena` asserted during RUN has no effect.
- Async reset mid-run: deassert `areset_n` between edges → `q`=0, `busy`=0, `done`=0 immediately, before the next clock edge.
